rt_out_receiver: RTL and testbench



---
 rtl/rt_rx_pkg.sv | 20 ++
 rtl/rt_sync_fifo.sv | 78 +++++++
 rtl/rt_out_receiver.sv | 138 +++++++++++++
 tb/tb_rt_out_receiver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_rx_pkg.sv
// rtl/rt_rx_pkg.sv - shared types for the router output-port receiver
// Purpose: receiver FSM state encoding, byte width and the FIFO entry type.
// Ports: none (package).
`timescale 1ns/1ps
package rt_rx_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } rx_byte_t;

endpackage

// File: rtl/rt_sync_fifo.sv
// rtl/rt_sync_fifo.sv - synchronous show-ahead FIFO
// Purpose: single-clock FIFO whose head entry is visible on rd_data while not empty.
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   wr_en, wr_data     : push request and entry; ignored when full unless a pop happens too
//   rd_en              : pop request; ignored when empty
//   rd_data            : head entry (zero while empty)
//   full, empty        : occupancy flags
`timescale 1ns/1ps
module rt_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // A pop frees the slot the push lands in, so a full FIFO may still accept.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Forced to zero when empty so stale storage never shows on the outputs.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/rt_out_receiver.sv
// rtl/rt_out_receiver.sv - router output-port receiver
// Purpose: deserialises LSB-first frames from one router output channel into a
//          buffered valid/ready byte stream with end-of-packet marking.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   dout, valido_n        : serial bit and its active-low qualifier
//   frameo_n              : active-low frame, high on the cycle of the last bit
//   m_valid/m_ready       : byte stream handshake, show-ahead
//   m_data, m_last        : byte value and end-of-packet flag
//   err_partial           : one-cycle pulse, frame ended mid-byte
//   overflow              : sticky, a byte was lost to a full FIFO
//   pkt_cnt               : packets completed cleanly, wraps
`timescale 1ns/1ps
module rt_out_receiver
    import rt_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dout,
    input  logic              valido_n,
    input  logic              frameo_n,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_last,
    output logic              err_partial,
    output logic              overflow,
    output logic [CNT_W-1:0]  pkt_cnt
);

    rx_state_e         state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic              seen_q, seen_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

    logic [BYTE_W-1:0] byte_asm;
    logic [2:0]        bits_after;
    logic              sample, frame_end, byte_done, lost, pop, clean_end;
    logic              fifo_full, fifo_empty;
    rx_byte_t          wr_byte, rd_byte;

    // The IDLE cycle that opens a frame already carries its first bit.
    assign sample    = !valido_n && ((state_q == RECV) || (state_q == IDLE && !frameo_n));
    assign frame_end = (state_q == RECV) && frameo_n;
    assign byte_done = sample && (bit_cnt_q == 3'd7);
    assign pop       = m_valid && m_ready;
    assign lost      = byte_done && fifo_full && !pop;
    assign bits_after = sample ? bit_cnt_q + 3'd1 : bit_cnt_q;
    assign wr_byte   = {frameo_n, byte_asm};

    always_comb begin
        byte_asm = shreg_q;
        byte_asm[bit_cnt_q] = dout;
    end

    rt_sync_fifo #(
        .WIDTH ($bits(rx_byte_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (byte_done && !lost),
        .wr_data (wr_byte),
        .rd_en   (pop),
        .rd_data (rd_byte),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            seen_q    <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            seen_q    <= seen_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!frameo_n) state_d = RECV;
            RECV: begin
                // A loss on the frame's last cycle has nothing left to drop.
                if (lost) begin
                    state_d = frameo_n ? IDLE : DROP;
                end else if (frameo_n) begin
                    state_d = IDLE;
                end
            end
            DROP: if (frameo_n) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and outputs
    always_comb begin
        shreg_d   = sample ? byte_asm : shreg_q;
        // Partial bits are discarded whenever the frame is left.
        bit_cnt_d = (state_d == RECV) ? bits_after : 3'd0;
        seen_d    = (state_d == RECV) && (seen_q || sample);
        // Frames without a single valid bit end silently.
        clean_end = frame_end && !lost && (bits_after == 3'd0) && (seen_q || sample);
        err_d     = frame_end && (bits_after != 3'd0);
        ovf_d     = ovf_q || lost;
        pkt_cnt_d = pkt_cnt_q;
        if (clean_end) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
    end

    assign m_valid     = !fifo_empty;
    assign m_data      = rd_byte.data;
    assign m_last      = rd_byte.last;
    assign err_partial = err_q;
    assign overflow    = ovf_q;
    assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_rt_out_receiver.sv
// tb/tb_rt_out_receiver.sv - scoreboard bench for rt_out_receiver
`timescale 1ns/1ps
module tb_rt_out_receiver;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset, dout, valido_n, frameo_n, m_ready;
    logic             m_valid, m_last, err_partial, overflow;
    logic [7:0]       m_data;
    logic [CNT_W-1:0] pkt_cnt;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int err_pulses = 0;
    logic [8:0] exp_q [$];

    always #5 clock = ~clock;

    rt_out_receiver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .dout        (dout),
        .valido_n    (valido_n),
        .frameo_n    (frameo_n),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .err_partial (err_partial),
        .overflow    (overflow),
        .pkt_cnt     (pkt_cnt)
    );

    // Monitor: pops the scoreboard on every accepted byte.
    always @(negedge clock) begin
        if (err_partial) err_pulses++;
        if (m_valid && m_ready) begin
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL byte_out: unexpected byte last=%0b data=%02h, none expected", m_last, m_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({m_last, m_data} !== e) begin
                    errors++;
                    $display("FAIL byte_out: got last=%0b data=%02h, expected last=%0b data=%02h",
                             m_last, m_data, e[8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic last, input logic [7:0] data);
        exp_q.push_back({last, data});
    endtask

    task automatic drive_bit(input logic d, input logic fr);
        dout = d;
        valido_n = 1'b0;
        frameo_n = fr;
        tick();
    endtask

    task automatic idle(input int n);
        dout = 1'b0;
        valido_n = 1'b1;
        frameo_n = 1'b1;
        repeat (n) tick();
    endtask

    // Sends nbits LSB-first; gap_len idle cycles after every third bit;
    // ready_bit >= 0 raises m_ready only on that bit's cycle.
    task automatic send_frame(input int nbits, input logic [63:0] bits,
                              input int gap_len, input int ready_bit);
        for (int i = 0; i < nbits; i++) begin
            if (ready_bit >= 0) m_ready = (i == ready_bit);
            drive_bit(bits[i], i == nbits - 1);
            if (gap_len > 0 && (i % 3) == 2 && i != nbits - 1) begin
                valido_n = 1'b1;
                frameo_n = 1'b0;
                repeat (gap_len) tick();
            end
        end
        if (ready_bit >= 0) m_ready = 1'b0;
        valido_n = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes outstanding, m_valid=%0b, expected 0", exp_q.size(), m_valid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rb;
        int p0;
        reset = 1'b1;
        dout = 1'b0;
        valido_n = 1'b1;
        frameo_n = 1'b1;
        m_ready = 1'b0;
        repeat (3) tick();
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_pkt_cnt", pkt_cnt, 0);
        reset = 1'b0;
        tick();

        // Single byte 0xA5
        m_ready = 1'b1;
        push_exp(1'b1, 8'hA5);
        send_frame(8, 64'hA5, 0, -1);
        chk("byte_latency_m_valid", m_valid, 1);
        chk("single_pkt_cnt", pkt_cnt, 1);
        wait_drain();

        // Three bytes with gaps
        push_exp(1'b0, 8'h01);
        push_exp(1'b0, 8'h80);
        push_exp(1'b1, 8'hFF);
        send_frame(24, 64'hFF8001, 2, -1);
        chk("gaps_pkt_cnt", pkt_cnt, 2);
        wait_drain();

        // Partial frame: 0x3C then four bits
        push_exp(1'b0, 8'h3C);
        send_frame(12, 64'h53C, 0, -1);
        chk("partial_err_high", err_partial, 1);
        chk("partial_pkt_cnt", pkt_cnt, 2);
        idle(1);
        chk("partial_err_low", err_partial, 0);
        wait_drain();

        // Frame with no valid bits
        valido_n = 1'b1;
        frameo_n = 1'b0;
        repeat (3) tick();
        frameo_n = 1'b1;
        tick();
        chk("empty_frame_err", err_partial, 0);
        chk("empty_frame_pkt_cnt", pkt_cnt, 2);
        idle(1);

        // Full FIFO with a pop on the completing cycle
        m_ready = 1'b0;
        push_exp(1'b0, 8'h10);
        push_exp(1'b0, 8'h20);
        push_exp(1'b0, 8'h30);
        push_exp(1'b0, 8'h40);
        push_exp(1'b1, 8'h50);
        send_frame(40, 64'h5040302010, 0, 39);
        chk("full_pop_overflow", overflow, 0);
        chk("full_pop_m_valid", m_valid, 1);
        chk("full_pop_pkt_cnt", pkt_cnt, 3);
        p0 = pops;
        m_ready = 1'b1;
        wait_drain();
        chk("full_pop_occupancy", pops - p0, 4);

        // Overflow: 6 bytes into a 4-deep FIFO
        m_ready = 1'b0;
        push_exp(1'b0, 8'h11);
        push_exp(1'b0, 8'h22);
        push_exp(1'b0, 8'h33);
        push_exp(1'b0, 8'h44);
        send_frame(48, 64'h665544332211, 0, -1);
        chk("overflow_flag", overflow, 1);
        chk("overflow_pkt_cnt", pkt_cnt, 3);
        p0 = pops;
        m_ready = 1'b1;
        wait_drain();
        chk("overflow_held", pops - p0, 4);
        push_exp(1'b0, 8'h5A);
        push_exp(1'b1, 8'hC3);
        send_frame(16, 64'hC35A, 0, -1);
        chk("after_overflow_pkt_cnt", pkt_cnt, 4);
        chk("overflow_sticky", overflow, 1);
        wait_drain();

        // Reset after 20 bits of a 4-byte packet
        m_ready = 1'b0;
        rb = 32'hDEADBEEF;
        for (int i = 0; i < 20; i++) drive_bit(rb[i], 1'b0);
        reset = 1'b1;
        valido_n = 1'b1;
        frameo_n = 1'b0;
        tick();
        chk("midreset_m_valid", m_valid, 0);
        chk("midreset_m_data", m_data, 0);
        chk("midreset_m_last", m_last, 0);
        chk("midreset_err", err_partial, 0);
        chk("midreset_overflow", overflow, 0);
        chk("midreset_pkt_cnt", pkt_cnt, 0);
        reset = 1'b0;
        m_ready = 1'b1;
        push_exp(1'b1, 8'h96);
        send_frame(8, 64'h96, 0, -1);
        chk("restart_pkt_cnt", pkt_cnt, 1);
        wait_drain();

        // Counter wrap: 17 packets from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int p = 0; p < 17; p++) begin
            logic [7:0] d;
            d = 8'(p * 13 + 7);
            push_exp(1'b1, d);
            send_frame(8, {56'h0, d}, 0, -1);
            idle(1);
            if (p == 15) chk("wrap_16_pkt_cnt", pkt_cnt, 0);
        end
        chk("wrap_17_pkt_cnt", pkt_cnt, 1);
        wait_drain();

        chk("err_pulse_count", err_pulses, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
